// File: rtl/result_drain_ctrl_pkg.sv
// Shared definitions for the result-buffer drain engine: FSM encoding and
// default word layout, matching the result-write path.
package result_drain_ctrl_pkg;

    localparam int unsigned DEF_ADDRESSSIZE    = 10;
    localparam int unsigned DEF_PARTIAL_SUM_BW = 20;
    localparam int unsigned DEF_MATRIX_SIZE    = 8;

    typedef enum logic [2:0] {
        DRAIN_IDLE  = 3'd0,
        DRAIN_FETCH = 3'd1,
        DRAIN_LOAD  = 3'd2,
        DRAIN_SEND  = 3'd3,
        DRAIN_DONE  = 3'd4
    } drain_state_e;

endpackage

// File: rtl/result_drain_ctrl_lane_serializer.sv
// Holds one fetched result row and presents it one lane at a time,
// lane 0 (LSBs) first.
module lane_serializer
    import result_drain_ctrl_pkg::*;
#(
    parameter int unsigned PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
    parameter int unsigned MATRIX_SIZE    = DEF_MATRIX_SIZE
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  load,
    input  logic                                  advance,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] row_data,
    output logic [PARTIAL_SUM_BW-1:0]             lane,
    output logic                                  row_last
);

    localparam int unsigned IDX_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

    logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] row_q;
    logic [IDX_W-1:0]                      idx;

    // Loading a new row restarts the lane walk at lane 0
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_q <= '0;
            idx   <= '0;
        end else if (load) begin
            row_q <= row_data;
            idx   <= '0;
        end else if (advance) begin
            idx   <= idx + IDX_W'(1);
        end
    end

    always_comb begin
        lane = '0;
        for (int unsigned k = 0; k < MATRIX_SIZE; k++) begin
            if (idx == IDX_W'(k)) begin
                lane = row_q[k*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
            end
        end
    end

    assign row_last = (idx == IDX_W'(MATRIX_SIZE - 1));

endmodule

// File: rtl/result_drain_ctrl.sv
// Walks a programmed range of result-buffer rows, reads each word from the
// result SRAM and streams it lane by lane toward the host.
module result_drain_ctrl
    import result_drain_ctrl_pkg::*;
#(
    parameter int unsigned ADDRESSSIZE    = DEF_ADDRESSSIZE,
    parameter int unsigned PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
    parameter int unsigned MATRIX_SIZE    = DEF_MATRIX_SIZE
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [ADDRESSSIZE-1:0]                base_addr,
    input  logic [ADDRESSSIZE:0]                  num_rows,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  sram_rd_en,
    output logic [ADDRESSSIZE-1:0]                sram_rd_addr,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_rd_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [PARTIAL_SUM_BW-1:0]             out_data,
    output logic                                  out_row_last,
    output logic                                  out_last
);

    drain_state_e             state, state_next;
    logic [ADDRESSSIZE-1:0]   addr;
    logic [ADDRESSSIZE:0]     remaining;
    logic                     handshake;
    logic                     row_last;

    assign handshake = (state == DRAIN_SEND) && out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= DRAIN_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort overrides every transition out of a non-idle state
    always_comb begin
        state_next = state;
        case (state)
            DRAIN_IDLE: begin
                if (start) begin
                    state_next = (num_rows != '0) ? DRAIN_FETCH : DRAIN_DONE;
                end
            end
            DRAIN_FETCH: state_next = DRAIN_LOAD;
            DRAIN_LOAD:  state_next = DRAIN_SEND;
            DRAIN_SEND: begin
                if (handshake && row_last) begin
                    state_next = (remaining != '0) ? DRAIN_FETCH : DRAIN_DONE;
                end
            end
            DRAIN_DONE:  state_next = DRAIN_IDLE;
            default:     state_next = DRAIN_IDLE;
        endcase
        if (abort && (state != DRAIN_IDLE)) begin
            state_next = DRAIN_IDLE;
        end
    end

    // Range is latched only when a drain is accepted; address wraps naturally
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr      <= '0;
            remaining <= '0;
        end else if ((state == DRAIN_IDLE) && start && (num_rows != '0)) begin
            addr      <= base_addr;
            remaining <= num_rows;
        end else if (state == DRAIN_LOAD) begin
            addr      <= addr + ADDRESSSIZE'(1);
            remaining <= remaining - (ADDRESSSIZE + 1)'(1);
        end
    end

    lane_serializer #(
        .PARTIAL_SUM_BW (PARTIAL_SUM_BW),
        .MATRIX_SIZE    (MATRIX_SIZE)
    ) u_lane_serializer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (state == DRAIN_LOAD),
        .advance  (handshake),
        .row_data (sram_rd_data),
        .lane     (out_data),
        .row_last (row_last)
    );

    assign busy         = (state != DRAIN_IDLE);
    assign done         = (state == DRAIN_DONE);
    assign sram_rd_en   = (state == DRAIN_FETCH);
    assign sram_rd_addr = addr;
    assign out_valid    = (state == DRAIN_SEND);
    assign out_row_last = out_valid && row_last;
    assign out_last     = out_row_last && (remaining == '0);

endmodule
